// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel coordinate, blanking, syncs and line/frame pulses.
// Optional build macro VGA_SYNC_DELAY_EN delays hsync/vsync by SYNC_DELAY pixel-enables.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 1280,
  parameter int unsigned H_FP       = 64,
  parameter int unsigned H_SYNC     = 136,
  parameter int unsigned H_BP       = 200,
  parameter int unsigned V_ACTIVE   = 800,
  parameter int unsigned V_FP       = 1,
  parameter int unsigned V_SYNC     = 3,
  parameter int unsigned V_BP       = 24,
  parameter bit          HS_POL     = 1'b0,
  parameter bit          VS_POL     = 1'b1,
  parameter int unsigned SYNC_DELAY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_ce,
  output logic [10:0] curr_x,
  output logic [9:0]  curr_y,
  output logic        active_area,
  output logic        hsync,
  output logic        vsync,
  output logic        line_start,
  output logic        frame_start
);

  localparam int unsigned HTotal  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HsStart = H_ACTIVE + H_FP;
  localparam int unsigned HsEnd   = HsStart + H_SYNC;
  localparam int unsigned VsStart = V_ACTIVE + V_FP;
  localparam int unsigned VsEnd   = VsStart + V_SYNC;
  localparam logic [10:0] HLast   = 11'(HTotal - 1);
  localparam logic [9:0]  VLast   = 10'(VTotal - 1);

`ifdef VGA_SYNC_DELAY_EN
  localparam int unsigned SyncDepth = SYNC_DELAY;
`else
  // SYNC_DELAY only matters when the delay build is selected.
  localparam int unsigned SyncDepth = 0 * SYNC_DELAY;
`endif

  logic [10:0] h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic        act_dec, hs_dec, vs_dec;

  logic [10:0] x_q;
  logic [9:0]  y_q;
  logic        act_q, ls_q, fs_q;
  // Index 0 holds the undelayed decode; higher indices are the optional delay stages.
  logic [SyncDepth:0] hs_pipe_q;
  logic [SyncDepth:0] vs_pipe_q;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_ce) begin
      if (h_cnt_q == HLast) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == VLast) ? '0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 11'd1;
      end
    end
    act_dec = (32'(h_cnt_q) < H_ACTIVE) && (32'(v_cnt_q) < V_ACTIVE);
    hs_dec  = (32'(h_cnt_q) >= HsStart) && (32'(h_cnt_q) < HsEnd);
    vs_dec  = (32'(v_cnt_q) >= VsStart) && (32'(v_cnt_q) < VsEnd);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      x_q       <= '0;
      y_q       <= '0;
      act_q     <= 1'b0;
      ls_q      <= 1'b0;
      fs_q      <= 1'b0;
      hs_pipe_q <= {(SyncDepth + 1){~HS_POL}};
      vs_pipe_q <= {(SyncDepth + 1){~VS_POL}};
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      if (pix_ce) begin
        x_q   <= h_cnt_q;
        y_q   <= v_cnt_q;
        act_q <= act_dec;
        ls_q  <= (h_cnt_q == '0);
        fs_q  <= (h_cnt_q == '0) && (v_cnt_q == '0);
        for (int i = SyncDepth; i > 0; i--) begin
          hs_pipe_q[i] <= hs_pipe_q[i-1];
          vs_pipe_q[i] <= vs_pipe_q[i-1];
        end
        hs_pipe_q[0] <= hs_dec ? HS_POL : ~HS_POL;
        vs_pipe_q[0] <= vs_dec ? VS_POL : ~VS_POL;
      end
    end
  end

  assign curr_x      = x_q;
  assign curr_y      = y_q;
  assign active_area = act_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign hsync       = hs_pipe_q[SyncDepth];
  assign vsync       = vs_pipe_q[SyncDepth];

endmodule
